// File: rtl/move_sequencer_pkg.sv
// Shared defaults for the move sequencer: board geometry, generator depth
// and the width of the exported FSM state.
package move_sequencer_pkg;

   localparam int DEFAULT_PIECE_BITS    = 4;
   localparam int DEFAULT_MAX_POSITIONS = 64;
   localparam int STATE_WIDTH           = 3;

endpackage

// File: rtl/move_sequencer.sv
// Walks the all_moves generator through one parent position: launch, wait for
// the move list, stream every child out on a valid/ready port, then release it.
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter int PIECE_WIDTH        = DEFAULT_PIECE_BITS,
   parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
   parameter int BOARD_WIDTH        = SIDE_WIDTH * 8,
   parameter int MAX_POSITIONS      = DEFAULT_MAX_POSITIONS,
   parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
   input  logic                          clk,
   input  logic                          reset,

   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [BOARD_WIDTH-1:0]        req_board,
   input  logic                          req_white_to_move,
   input  logic [3:0]                    req_castle_mask,
   input  logic [3:0]                    req_en_passant_col,
   input  logic                          abort,

   output logic                          gen_board_valid,
   output logic [BOARD_WIDTH-1:0]        gen_board,
   output logic                          gen_white_to_move,
   output logic [3:0]                    gen_castle_mask,
   output logic [3:0]                    gen_en_passant_col,
   output logic [MAX_POSITIONS_LOG2-1:0] gen_move_index,
   output logic                          gen_clear_moves,
   input  logic                          gen_moves_ready,
   input  logic [MAX_POSITIONS_LOG2-1:0] gen_move_count,
   input  logic [BOARD_WIDTH-1:0]        gen_board_out,
   input  logic                          gen_white_to_move_out,
   input  logic [3:0]                    gen_castle_mask_out,
   input  logic [3:0]                    gen_en_passant_col_out,

   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BOARD_WIDTH-1:0]        out_board,
   output logic                          out_white_to_move,
   output logic [3:0]                    out_castle_mask,
   output logic [3:0]                    out_en_passant_col,
   output logic [MAX_POSITIONS_LOG2-1:0] out_index,
   output logic                          out_last,

   output logic                          done,
   output logic                          done_aborted,
   output logic [MAX_POSITIONS_LOG2-1:0] done_count,

   output logic [STATE_WIDTH-1:0]        debug_state
);

   // Both ports are valid/ready: a transfer happens on a rising clk edge where
   // valid and ready are both high; valid, once raised, holds with its payload
   // until that transfer (or an abort on the output side).
   localparam logic [STATE_WIDTH-1:0] S_IDLE     = 3'd0;
   localparam logic [STATE_WIDTH-1:0] S_LAUNCH   = 3'd1;
   localparam logic [STATE_WIDTH-1:0] S_WAIT_GEN = 3'd2;
   localparam logic [STATE_WIDTH-1:0] S_ADDR     = 3'd3;
   localparam logic [STATE_WIDTH-1:0] S_CAPTURE  = 3'd4;
   localparam logic [STATE_WIDTH-1:0] S_PRESENT  = 3'd5;
   localparam logic [STATE_WIDTH-1:0] S_CLEAR    = 3'd6;

   logic [STATE_WIDTH-1:0]        state_q;
   logic [STATE_WIDTH-1:0]        state_d;
   logic                          aborted_q;
   logic [MAX_POSITIONS_LOG2-1:0] index_q;
   logic [MAX_POSITIONS_LOG2-1:0] count_q;
   logic                          handshake;
   logic                          clear_exit;

   assign handshake  = out_valid && out_ready;
   assign clear_exit = (state_q == S_CLEAR) && !gen_moves_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_GEN;
         end
         S_WAIT_GEN: begin
            // Generation cannot be cancelled, so an abort only takes effect here.
            if (gen_moves_ready) begin
               if (aborted_q || abort || (gen_move_count == '0)) begin
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            state_d = abort ? S_CLEAR : S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d = abort ? S_CLEAR : S_PRESENT;
         end
         S_PRESENT: begin
            if (abort) begin
               state_d = S_CLEAR;
            end else if (handshake) begin
               state_d = out_last ? S_CLEAR : S_ADDR;
            end
         end
         S_CLEAR: begin
            if (!gen_moves_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready       = (state_q == S_IDLE);
      gen_board_valid = (state_q == S_LAUNCH);
      gen_clear_moves = (state_q == S_CLEAR);
      gen_move_index  = index_q;
      done_count      = count_q;
      debug_state     = state_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gen_board          <= '0;
         gen_white_to_move  <= 1'b0;
         gen_castle_mask    <= '0;
         gen_en_passant_col <= '0;
         aborted_q          <= 1'b0;
         index_q            <= '0;
         count_q            <= '0;
      end else begin
         if (state_q == S_IDLE) begin
            if (req_valid) begin
               gen_board          <= req_board;
               gen_white_to_move  <= req_white_to_move;
               gen_castle_mask    <= req_castle_mask;
               gen_en_passant_col <= req_en_passant_col;
               aborted_q          <= 1'b0;
            end
         end else if (abort) begin
            aborted_q <= 1'b1;
         end
         if ((state_q == S_WAIT_GEN) && gen_moves_ready) begin
            count_q <= gen_move_count;
            index_q <= '0;
         end
         // An abort beats a simultaneous handshake, so the index stays put.
         if ((state_q == S_PRESENT) && handshake && !abort && !out_last) begin
            index_q <= index_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid          <= 1'b0;
         out_board          <= '0;
         out_white_to_move  <= 1'b0;
         out_castle_mask    <= '0;
         out_en_passant_col <= '0;
         out_index          <= '0;
         out_last           <= 1'b0;
         done               <= 1'b0;
         done_aborted       <= 1'b0;
      end else begin
         out_valid <= (state_d == S_PRESENT);
         // RAM read data is valid in CAPTURE, one cycle after the ADDR cycle.
         if (state_q == S_CAPTURE) begin
            out_board          <= gen_board_out;
            out_white_to_move  <= gen_white_to_move_out;
            out_castle_mask    <= gen_castle_mask_out;
            out_en_passant_col <= gen_en_passant_col_out;
            out_index          <= index_q;
            out_last           <= (index_q == count_q - 1'b1);
         end
         done         <= clear_exit;
         done_aborted <= clear_exit && (aborted_q || abort);
      end
   end

endmodule
